// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types: the functional-unit result record carried from each source to the
// register-file write port.
package wb_arbiter_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  id;
    logic [5:0]  prd;
    logic [31:0] rdval;
  } fu_output_t;

  localparam int FU_OUT_W = $bits(fu_output_t);

endpackage

// File: rtl/squash_if.sv
// Pipeline flush request; the producer drives valid for one cycle per flush.
interface squash_if;
  logic valid;

  modport master (output valid);
  modport slave  (input  valid);
endinterface

// File: rtl/wb_fifo.sv
// Per-source result FIFO; head visible the cycle after a push, pop takes effect on the same edge.
// Backpressure: a push to a full FIFO is ignored unless the FIFO pops in that cycle; flush empties it.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  fu_output_t                 push_dat,
  input  logic                       pop,
  output fu_output_t                 head_dat,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  fu_output_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush && do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter over NFU result FIFOs; latency 1 cycle (0 with WB_ARBITER_BYPASS_EN).
// Backpressure: none upstream, fu_stall_o asks sources to hold off; full-FIFO drops set sticky overflow_o.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NFU   = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  fu_output_t       fu_i [NFU],
  input  logic [NFU-1:0]   fu_i_valid,
  output logic [NFU-1:0]   fu_stall_o,
  output fu_output_t       wb_o,
  output logic             wb_o_valid,
  output logic             overflow_o,
  squash_if.slave          squash_io
);
  localparam int IW = (NFU > 1) ? $clog2(NFU) : 1;
  localparam int CW = $clog2(DEPTH+1);

  fu_output_t     head [NFU];
  logic [CW-1:0]  cnt  [NFU];
  logic [NFU-1:0] full, empty, push, pop, drop, req;
  logic [IW-1:0]  rr_q, gnt_idx, rr_next;
  logic           gnt_any, gnt_vld, byp, squash;

  // First requester at or after the pointer, as {found, index}.
  function automatic logic [IW:0] rr_pick(input logic [NFU-1:0] r, input logic [IW-1:0] p);
    logic [IW:0]   res;
    logic [IW-1:0] idx;
    res = '0;
    for (int k = 0; k < NFU; k++) begin
      idx = IW'((int'(p) + k) % NFU);
      if (!res[IW] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign squash = squash_io.valid;

  always_comb begin
    req  = ~empty;
    wb_o = '0;
    byp  = 1'b0;
    pop  = '0;
    push = '0;
    drop = '0;
`ifdef WB_ARBITER_BYPASS_EN
    req = ~empty | fu_i_valid;
`endif
    {gnt_any, gnt_idx} = rr_pick(req, rr_q);
    gnt_vld = gnt_any && rstn && !squash;
    rr_next = IW'((int'(gnt_idx) + 1) % NFU);
`ifdef WB_ARBITER_BYPASS_EN
    byp = gnt_vld && empty[gnt_idx];
    if (gnt_vld) wb_o = byp ? fu_i[gnt_idx] : head[gnt_idx];
`else
    if (gnt_vld) wb_o = head[gnt_idx];
`endif
    for (int i = 0; i < NFU; i++) begin
      pop[i]        = gnt_vld && (gnt_idx == IW'(i)) && !empty[i];
      push[i]       = fu_i_valid[i] && !squash && !(byp && (gnt_idx == IW'(i)));
      drop[i]       = push[i] && full[i] && !pop[i];
      fu_stall_o[i] = rstn && (cnt[i] >= CW'(DEPTH-1));
    end
  end

  assign wb_o_valid = gnt_vld;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_q       <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (gnt_vld) rr_q <= rr_next;
      if (|drop)   overflow_o <= 1'b1;
    end
  end

  for (genvar g = 0; g < NFU; g++) begin : g_fifo
    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rstn     (rstn),
      .flush    (squash),
      .push     (push[g]),
      .push_dat (fu_i[g]),
      .pop      (pop[g]),
      .head_dat (head[g]),
      .full     (full[g]),
      .empty    (empty[g]),
      .count    (cnt[g])
    );
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised bench for wb_arbiter against a queue-based reference of the arbitration rules.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NFU   = 4;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           rstn;
  fu_output_t     fu_i [NFU];
  logic [NFU-1:0] fu_i_valid;
  logic [NFU-1:0] fu_stall_o;
  fu_output_t     wb_o;
  logic           wb_o_valid;
  logic           overflow_o;

  squash_if sq_if ();

  always #5 clk = ~clk;

  wb_arbiter #(.NFU(NFU), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fu_i       (fu_i),
    .fu_i_valid (fu_i_valid),
    .fu_stall_o (fu_stall_o),
    .wb_o       (wb_o),
    .wb_o_valid (wb_o_valid),
    .overflow_o (overflow_o),
    .squash_io  (sq_if)
  );

  int checks = 0;
  int errors = 0;

  fu_output_t mq [NFU][$];
  int         m_rr  = 0;
  bit         m_ovf = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit rst_n, input bit sq, input logic [NFU-1:0] v);
    rstn         = rst_n;
    sq_if.valid  = sq;
    fu_i_valid   = v;
    for (int i = 0; i < NFU; i++) begin
      fu_i[i].pc    = $urandom;
      fu_i[i].id    = 8'(i);
      fu_i[i].prd   = 6'($urandom);
      fu_i[i].rdval = $urandom;
    end
  endtask

  // Check outputs against the model mid-cycle, then advance the model to the next edge.
  task automatic tick();
    logic [NFU-1:0] req, exp_stall;
    fu_output_t     exp_wb;
    int             g;
    bit             byp;
    @(negedge clk);
    g      = -1;
    byp    = 1'b0;
    exp_wb = '0;
    for (int i = 0; i < NFU; i++) begin
      req[i] = mq[i].size() > 0;
`ifdef WB_ARBITER_BYPASS_EN
      req[i] = req[i] || fu_i_valid[i];
`endif
      exp_stall[i] = rstn && (mq[i].size() >= DEPTH - 1);
    end
    if (rstn && !sq_if.valid)
      for (int k = 0; k < NFU; k++)
        if (g < 0 && req[(m_rr + k) % NFU]) g = (m_rr + k) % NFU;
    if (g >= 0) begin
      if (mq[g].size() > 0) exp_wb = mq[g][0];
      else begin
        exp_wb = fu_i[g];
        byp    = 1'b1;
      end
    end
    chk("wb_vld", wb_o_valid, g >= 0);
    chk("wb_dat", wb_o, exp_wb);
    chk("ovf", overflow_o, m_ovf);
    chk("stall", fu_stall_o, exp_stall);

    if (!rstn) begin
      for (int i = 0; i < NFU; i++) mq[i].delete();
      m_rr  = 0;
      m_ovf = 1'b0;
    end else if (sq_if.valid) begin
      for (int i = 0; i < NFU; i++) mq[i].delete();
    end else begin
      if (g >= 0) begin
        if (!byp) void'(mq[g].pop_front());
        m_rr = (g + 1) % NFU;
      end
      for (int i = 0; i < NFU; i++)
        if (fu_i_valid[i] && !(byp && g == i)) begin
          if (mq[i].size() < DEPTH) mq[i].push_back(fu_i[i]);
          else m_ovf = 1'b1;
        end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    drive(1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, '0);
    chk("rst_vld", wb_o_valid, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_stall", fu_stall_o, '0);
    tick();

    // Single push on source 2
    drive(1'b1, 1'b0, 4'b0100);
    fu_i[2].rdval = 32'h1234;
    tick();
    drive(1'b1, 1'b0, '0);
`ifndef WB_ARBITER_BYPASS_EN
    chk("single_vld", wb_o_valid, 1'b1);
    chk("single_rd", wb_o.rdval, 32'h1234);
`endif
    tick();

    // All sources valid once from rr 0: grants 0,1,2,3
    drive(1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, 4'hF);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, '0);
`ifndef WB_ARBITER_BYPASS_EN
      chk("rr_order", wb_o.id, 8'(k));
`endif
      tick();
    end

    // Saturation: every source pushes every cycle until results are dropped
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 4'hF);
      tick();
    end
    drive(1'b1, 1'b0, '0);
    chk("sat_ovf", overflow_o, 1'b1);
    chk("sat_stall", fu_stall_o, 4'hF);
    tick();

    // Squash with queued entries and a same-cycle input
    drive(1'b0, 1'b0, '0);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 4'hF);
      tick();
    end
    drive(1'b1, 1'b1, 4'b0010);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, '0);
      chk("squash_vld", wb_o_valid, 1'b0);
      chk("squash_stall", fu_stall_o, '0);
      tick();
    end

    // Random traffic with occasional squash and reset
    for (int n = 0; n < 3000; n++) begin
      logic [NFU-1:0] v;
      for (int i = 0; i < NFU; i++) v[i] = ($urandom_range(0, 2) == 0) || (n % 200 < 12);
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0), v);
      tick();
    end

    // Reset mid-traffic
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 4'hF);
      tick();
    end
    drive(1'b0, 1'b0, 4'hF);
    tick();
    drive(1'b1, 1'b0, '0);
    chk("midrst_vld", wb_o_valid, 1'b0);
    chk("midrst_ovf", overflow_o, 1'b0);
    chk("midrst_stall", fu_stall_o, '0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
